// File: rtl/mix_columns_seq.sv
// Multi-cycle AES MixColumns / InvMixColumns engine with valid/ready on both sides.
// Transforms COLS_PER_CYCLE columns per clock and holds the result until it is taken.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q;
  logic [127:0] work_q;
  logic [127:0] out_data_q, out_data_d;
  logic         inv_q;
  logic [1:0]   cnt_q;
  int           col;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m4 [4];
    logic [7:0]  m8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (!inv) begin
        res[31-8*i -: 8] = m2[i] ^ (m2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end else begin
        // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3, each built from the x2/x4/x8 chain
        res[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                         ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                         ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                         ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
      end
    end
    return res;
  endfunction

  always_comb begin
    out_data_d = out_data_q;
    col        = 0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col = int'(cnt_q) + j;
      out_data_d[127-32*col -: 32] = mix_col(work_q[127-32*col -: 32], inv_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      out_data_q <= '0;
      inv_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            inv_q   <= in_inv;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          out_data_q <= out_data_d;
          cnt_q      <= cnt_q + STEP;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY) || (state_q == DONE);
  assign out_data  = out_data_q;

endmodule
